// File: rtl/estado_pkg.sv
// Shared state encodings for the level-monitor FSM and the seven-segment decoder.
// It also provides a saturating subtract used for offset correction.
package estado_pkg;

   typedef enum logic [2:0] {
      NADA        = 3'b000,
      AVISO       = 3'b001,
      CERO        = 3'b010,
      EMERGENCIA  = 3'b011,
      VENTILACION = 3'b100
   } estado_t;

   // Returns a - b, or zero when b is not below a. The result never wraps.
   function automatic logic [7:0] resta_sat(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] r;
      if (a > b) begin
         r = a - b;
      end else begin
         r = 8'd0;
      end
      return r;
   endfunction

endpackage

// File: rtl/contador_confirmacion.sv
// Counts consecutive qualifying samples. The counter saturates at N_CONFIRM.
// hecho is high while the sample that completes the run is being accepted.
module contador_confirmacion #(
   parameter int N_CONFIRM = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic valid,
   input  logic cumple,
   output logic hecho
);

   localparam logic [3:0] OBJETIVO = 4'(N_CONFIRM - 1);
   localparam logic [3:0] MAXIMO   = 4'(N_CONFIRM);

   logic [3:0] cuenta_r;

   assign hecho = valid & cumple & (cuenta_r >= OBJETIVO);

   // Consecutive-sample counter; cycles without a strobe leave it unchanged.
   always_ff @(posedge clk) begin
      if (reset) begin
         cuenta_r <= 4'd0;
      end else if (clr) begin
         cuenta_r <= 4'd0;
      end else if (valid) begin
         if (!cumple) begin
            cuenta_r <= 4'd0;
         end else if (cuenta_r < MAXIMO) begin
            cuenta_r <= cuenta_r + 4'd1;
         end else begin
            cuenta_r <= cuenta_r;
         end
      end else begin
         cuenta_r <= cuenta_r;
      end
   end

endmodule

// File: rtl/control_estado.sv
// Level-monitor state controller. It captures an offset, raises warning and emergency states
// with sample confirmation, and runs a timed ventilation phase. All outputs are registered.
module control_estado
   import estado_pkg::*;
#(
   parameter logic [7:0]  UMBRAL_AVISO = 8'd100,
   parameter logic [7:0]  UMBRAL_EMERG = 8'd180,
   parameter int          N_CONFIRM    = 4,
   parameter logic [15:0] T_VENT       = 16'd50000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] nivel,
   input  logic       nivel_valido,
   input  logic       btn_ack,
   output logic [2:0] estado,
   output logic       alarma,
   output logic       ventilador
);

   estado_t     estado_r;
   estado_t     estado_sig;
   logic [7:0]  offset_r;
   logic [7:0]  nivel_corr_s;
   logic [15:0] timer_r;
   logic        ack_pend_r;
   logic        alarma_r;
   logic        ventilador_r;
   logic        cambio_s;
   logic        hecho_aviso_s;
   logic        hecho_emerg_s;
   logic        hecho_bajo_s;
   logic        valido_eval_s;

   assign nivel_corr_s  = resta_sat(nivel, offset_r);
   assign cambio_s      = (estado_sig != estado_r);
   // The calibration sample in CERO is never evaluated against the thresholds.
   assign valido_eval_s = nivel_valido & (estado_r != CERO);

   contador_confirmacion #(.N_CONFIRM(N_CONFIRM)) u_conf_aviso (
      .clk(clk), .reset(reset), .clr(cambio_s), .valid(valido_eval_s),
      .cumple(nivel_corr_s >= UMBRAL_AVISO), .hecho(hecho_aviso_s)
   );

   contador_confirmacion #(.N_CONFIRM(N_CONFIRM)) u_conf_emerg (
      .clk(clk), .reset(reset), .clr(cambio_s), .valid(valido_eval_s),
      .cumple(nivel_corr_s >= UMBRAL_EMERG), .hecho(hecho_emerg_s)
   );

   contador_confirmacion #(.N_CONFIRM(N_CONFIRM)) u_conf_bajo (
      .clk(clk), .reset(reset), .clr(cambio_s), .valid(valido_eval_s),
      .cumple(nivel_corr_s < UMBRAL_AVISO), .hecho(hecho_bajo_s)
   );

   // Next-state decode; unknown encodings fall back to CERO.
   always_comb begin
      estado_sig = estado_r;
      case (estado_r)
         CERO: begin
            if (nivel_valido) estado_sig = NADA;
            else              estado_sig = CERO;
         end
         NADA: begin
            if (hecho_aviso_s) estado_sig = AVISO;
            else               estado_sig = NADA;
         end
         AVISO: begin
            if (hecho_emerg_s)     estado_sig = EMERGENCIA;
            else if (hecho_bajo_s) estado_sig = NADA;
            else                   estado_sig = AVISO;
         end
         EMERGENCIA: begin
            if (nivel_valido && (nivel_corr_s < UMBRAL_EMERG) && (ack_pend_r || btn_ack))
               estado_sig = VENTILACION;
            else
               estado_sig = EMERGENCIA;
         end
         VENTILACION: begin
            if (hecho_emerg_s)          estado_sig = EMERGENCIA;
            else if (timer_r == 16'd0)  estado_sig = NADA;
            else                        estado_sig = VENTILACION;
         end
         default: estado_sig = CERO;
      endcase
   end

   // State, outputs, offset, ack latch and ventilation timer.
   always_ff @(posedge clk) begin
      if (reset) begin
         estado_r     <= CERO;
         alarma_r     <= 1'b0;
         ventilador_r <= 1'b0;
         offset_r     <= 8'd0;
         ack_pend_r   <= 1'b0;
         timer_r      <= 16'd0;
      end else begin
         estado_r     <= estado_sig;
         alarma_r     <= (estado_sig == EMERGENCIA);
         ventilador_r <= (estado_sig == EMERGENCIA) || (estado_sig == VENTILACION);

         if ((estado_r == CERO) && nivel_valido) offset_r <= nivel;
         else                                    offset_r <= offset_r;

         if ((estado_r == EMERGENCIA) && (estado_sig == EMERGENCIA))
            ack_pend_r <= ack_pend_r | btn_ack;
         else
            ack_pend_r <= 1'b0;

         // The timer loads on entry, so VENTILACION lasts exactly T_VENT cycles.
         if ((estado_sig == VENTILACION) && (estado_r != VENTILACION))
            timer_r <= T_VENT - 16'd1;
         else if ((estado_r == VENTILACION) && (timer_r != 16'd0))
            timer_r <= timer_r - 16'd1;
         else
            timer_r <= 16'd0;
      end
   end

   assign estado     = estado_r;
   assign alarma     = alarma_r;
   assign ventilador = ventilador_r;

endmodule

// File: tb/tb_control_estado.sv
// Directed bench for control_estado with N_CONFIRM=3 and T_VENT=10.
// Each vector carries a hand-computed expected value.
module tb_control_estado;

   logic       clk;
   logic       reset;
   logic [7:0] nivel;
   logic       nivel_valido;
   logic       btn_ack;
   logic [2:0] estado;
   logic       alarma;
   logic       ventilador;

   int n_checks;
   int n_errors;

   control_estado #(
      .UMBRAL_AVISO(8'd100),
      .UMBRAL_EMERG(8'd180),
      .N_CONFIRM(3),
      .T_VENT(16'd10)
   ) dut (
      .clk(clk), .reset(reset), .nivel(nivel), .nivel_valido(nivel_valido),
      .btn_ack(btn_ack), .estado(estado), .alarma(alarma), .ventilador(ventilador)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic comprobar(input string tag, input logic [7:0] obs, input logic [7:0] esp);
      n_checks = n_checks + 1;
      if (obs !== esp) begin
         n_errors = n_errors + 1;
         $display("FAIL %s: observed %0d expected %0d", tag, obs, esp);
      end
   endtask

   task automatic ciclos(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic muestra(input logic [7:0] v);
      nivel        = v;
      nivel_valido = 1'b1;
      @(posedge clk);
      #1;
      nivel_valido = 1'b0;
      btn_ack      = 1'b0;
   endtask

   task automatic salidas(input string tag, input logic [2:0] e, input logic a, input logic v);
      comprobar({tag, ".estado"}, {5'd0, estado}, {5'd0, e});
      comprobar({tag, ".alarma"}, {7'd0, alarma}, {7'd0, a});
      comprobar({tag, ".vent"},   {7'd0, ventilador}, {7'd0, v});
   endtask

   initial begin
      n_checks     = 0;
      n_errors     = 0;
      reset        = 1'b1;
      nivel        = 8'd0;
      nivel_valido = 1'b0;
      btn_ack      = 1'b0;
      ciclos(2);
      salidas("reset", 3'b010, 1'b0, 1'b0);
      comprobar("reset.offset", dut.offset_r, 8'd0);
      reset = 1'b0;
      ciclos(1);
      comprobar("cero_espera", {5'd0, estado}, 8'd2);

      // Calibration: offset becomes 20
      muestra(8'd20);
      salidas("calib", 3'b000, 1'b0, 1'b0);
      comprobar("calib.offset", dut.offset_r, 8'd20);

      // Corrected 99 is just under the warning threshold
      muestra(8'd119); muestra(8'd119); muestra(8'd119);
      comprobar("bajo_umbral", {5'd0, estado}, 8'd0);

      // Broken run 130,50,130 does not confirm
      muestra(8'd130); muestra(8'd50); muestra(8'd130);
      comprobar("racha_rota", {5'd0, estado}, 8'd0);
      muestra(8'd50);

      // Idle cycles between samples keep the count
      muestra(8'd130); muestra(8'd130);
      comprobar("aviso_2de3", {5'd0, estado}, 8'd0);
      ciclos(2);
      muestra(8'd130);
      salidas("aviso", 3'b001, 1'b0, 1'b0);

      // AVISO back to NADA
      muestra(8'd40); muestra(8'd40);
      comprobar("nada_2de3", {5'd0, estado}, 8'd1);
      muestra(8'd40);
      comprobar("aviso_a_nada", {5'd0, estado}, 8'd0);

      // A 120 sample (corrected 100) sits exactly on the threshold
      muestra(8'd120); muestra(8'd120); muestra(8'd120);
      comprobar("aviso_limite", {5'd0, estado}, 8'd1);
      muestra(8'd220); muestra(8'd220);
      comprobar("emerg_2de3", {5'd0, estado}, 8'd1);
      muestra(8'd220);
      salidas("emerg", 3'b011, 1'b1, 1'b1);

      // Low sample without ack stays in EMERGENCIA
      muestra(8'd100);
      comprobar("sin_ack", {5'd0, estado}, 8'd3);
      btn_ack = 1'b1;
      ciclos(1);
      btn_ack = 1'b0;
      comprobar("ack_sin_muestra", {5'd0, estado}, 8'd3);
      muestra(8'd100);
      salidas("vent", 3'b100, 1'b0, 1'b1);
      ciclos(9);
      comprobar("vent_9", {5'd0, estado}, 8'd4);
      ciclos(1);
      salidas("vent_fin", 3'b000, 1'b0, 1'b0);

      // Timer expiry coincides with the third 220 sample: emergency wins
      muestra(8'd130); muestra(8'd130); muestra(8'd130);
      muestra(8'd220); muestra(8'd220); muestra(8'd220);
      comprobar("emerg_2", {5'd0, estado}, 8'd3);
      btn_ack = 1'b1;
      muestra(8'd100);
      comprobar("vent_ack_mismo", {5'd0, estado}, 8'd4);
      ciclos(7);
      muestra(8'd220); muestra(8'd220);
      comprobar("vent_prio_prev", {5'd0, estado}, 8'd4);
      muestra(8'd220);
      salidas("vent_prio", 3'b011, 1'b1, 1'b1);

      // Reset in EMERGENCIA
      reset = 1'b1;
      ciclos(1);
      salidas("reset_emerg", 3'b010, 1'b0, 1'b0);
      comprobar("reset_emerg.offset", dut.offset_r, 8'd0);
      reset = 1'b0;

      // Acknowledge outside EMERGENCIA has no lasting effect
      muestra(8'd0);
      btn_ack = 1'b1;
      ciclos(1);
      btn_ack = 1'b0;
      muestra(8'd200); muestra(8'd200); muestra(8'd200);
      muestra(8'd200); muestra(8'd200); muestra(8'd200);
      comprobar("emerg_3", {5'd0, estado}, 8'd3);
      muestra(8'd100);
      comprobar("ack_ignorado", {5'd0, estado}, 8'd3);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
